// File: rtl/satarx_descrambler.sv
// SATA link-layer receive descrambler: XORs frame payload words with the per-frame LFSR sequence,
// enforces MAX_WORDS and closes aborted frames. Define SATARX_DESCRAMBLER_SKID_EN for a registered-ready input skid.
module satarx_descrambler #(
    parameter logic [15:0] POLYNOMIAL = 16'ha011,
    parameter logic [15:0] INITIAL    = 16'hffff,
    parameter int          MAX_WORDS  = 2049
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESET,
    input  logic        i_abort,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TLAST,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TLAST,
    output logic        M_AXIS_TABORT,
    output logic        o_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_DROP  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    localparam logic [11:0] LAST_IDX = 12'(MAX_WORDS - 1);

    // Runs the Galois LFSR 32 steps; returns {next fill, prn word} with step k landing on bit k.
    function automatic logic [47:0] lfsr_word(input logic [15:0] fill);
        logic [15:0] f;
        logic [31:0] prn;
        f   = fill;
        prn = '0;
        for (int k = 0; k < 32; k++) begin
            prn[k] = f[15];
            f      = {f[14:0], 1'b0} ^ (f[15] ? POLYNOMIAL : 16'h0000);
        end
        return {f, prn};
    endfunction

    state_t      r_state;
    logic [15:0] r_fill;
    logic [11:0] r_count;
    logic        r_vld_p1;
    logic [31:0] r_data_p1;
    logic        r_last_p1;
    logic        r_abort_p1;
    logic        r_ovf_p1;

    state_t      w_state_nxt;
    logic [15:0] w_fill_nxt;
    logic [11:0] w_count_nxt;
    logic        w_vld_nxt;
    logic [31:0] w_data_nxt;
    logic        w_last_nxt;
    logic        w_abort_nxt;
    logic        w_ovf_nxt;

    logic        w_out_free;
    logic        w_s_acc;
    logic        w_cand_vld;
    logic [31:0] w_cand_data;
    logic        w_cand_last;
    logic        w_take;
    logic [47:0] w_lfsr;

    assign w_out_free = !r_vld_p1 || M_AXIS_TREADY;
    assign w_take     = w_cand_vld && w_out_free && !i_abort;
    assign w_lfsr     = lfsr_word(r_fill);

`ifdef SATARX_DESCRAMBLER_SKID_EN
    logic        r_skid_vld;
    logic [31:0] r_skid_data;
    logic        r_skid_last;
    logic        r_tready;
    logic        w_skid_vld_nxt;

    assign S_AXIS_TREADY = r_tready;
    assign w_s_acc       = S_AXIS_TVALID && r_tready;
    assign w_cand_vld    = r_skid_vld || w_s_acc;
    assign w_cand_data   = r_skid_vld ? r_skid_data : S_AXIS_TDATA;
    assign w_cand_last   = r_skid_vld ? r_skid_last : S_AXIS_TLAST;

    // Skid holds at most one word; an abort discards whatever it holds along with the frame.
    always_comb begin
        w_skid_vld_nxt = r_skid_vld;
        if (i_abort) begin
            w_skid_vld_nxt = 1'b0;
        end else if (r_skid_vld) begin
            if (w_take) begin
                w_skid_vld_nxt = 1'b0;
            end
        end else if (w_s_acc && !w_out_free) begin
            w_skid_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
            r_skid_last <= 1'b0;
            r_tready    <= 1'b0;
        end else begin
            r_skid_vld <= w_skid_vld_nxt;
            r_tready   <= !w_skid_vld_nxt && (w_state_nxt != ST_ABORT);
            if (!r_skid_vld && w_s_acc && !w_out_free) begin
                r_skid_data <= S_AXIS_TDATA;
                r_skid_last <= S_AXIS_TLAST;
            end
        end
    end
`else
    assign S_AXIS_TREADY = !S_AXI_ARESET && (r_state != ST_ABORT) && w_out_free;
    assign w_s_acc       = S_AXIS_TVALID && S_AXIS_TREADY;
    assign w_cand_vld    = w_s_acc;
    assign w_cand_data   = S_AXIS_TDATA;
    assign w_cand_last   = S_AXIS_TLAST;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        w_count_nxt = r_count;
        w_ovf_nxt   = 1'b0;
        if (w_out_free) begin
            w_vld_nxt   = 1'b0;
            w_data_nxt  = '0;
            w_last_nxt  = 1'b0;
            w_abort_nxt = 1'b0;
        end else begin
            w_vld_nxt   = r_vld_p1;
            w_data_nxt  = r_data_p1;
            w_last_nxt  = r_last_p1;
            w_abort_nxt = r_abort_p1;
        end

        case (r_state)
            ST_IDLE, ST_FRAME: begin
                if (i_abort) begin
                    w_state_nxt = (r_state == ST_FRAME) ? ST_ABORT : ST_IDLE;
                    w_fill_nxt  = INITIAL;
                    w_count_nxt = '0;
                end else if (w_take) begin
                    w_vld_nxt   = 1'b1;
                    w_data_nxt  = w_cand_data ^ w_lfsr[31:0];
                    w_last_nxt  = w_cand_last;
                    w_abort_nxt = 1'b0;
                    w_fill_nxt  = w_lfsr[47:32];
                    w_count_nxt = r_count + 12'd1;
                    w_state_nxt = ST_FRAME;
                    if (w_cand_last) begin
                        w_state_nxt = ST_IDLE;
                        w_fill_nxt  = INITIAL;
                        w_count_nxt = '0;
                    end else if (r_count == LAST_IDX) begin
                        // Oversized frame: close it here as truncated and swallow the rest.
                        w_last_nxt  = 1'b1;
                        w_abort_nxt = 1'b1;
                        w_ovf_nxt   = 1'b1;
                        w_state_nxt = ST_DROP;
                        w_fill_nxt  = INITIAL;
                        w_count_nxt = '0;
                    end
                end
            end
            ST_DROP: begin
                if (i_abort || (w_take && w_cand_last)) begin
                    w_state_nxt = ST_IDLE;
                    w_fill_nxt  = INITIAL;
                    w_count_nxt = '0;
                end
            end
            ST_ABORT: begin
                if (w_out_free) begin
                    w_vld_nxt   = 1'b1;
                    w_data_nxt  = '0;
                    w_last_nxt  = 1'b1;
                    w_abort_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_fill_nxt  = INITIAL;
                w_count_nxt = '0;
            end
        endcase
    end

    // Stage p1: output register feeding M_AXIS.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state    <= ST_IDLE;
            r_fill     <= INITIAL;
            r_count    <= '0;
            r_vld_p1   <= 1'b0;
            r_data_p1  <= '0;
            r_last_p1  <= 1'b0;
            r_abort_p1 <= 1'b0;
            r_ovf_p1   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill     <= w_fill_nxt;
            r_count    <= w_count_nxt;
            r_vld_p1   <= w_vld_nxt;
            r_data_p1  <= w_data_nxt;
            r_last_p1  <= w_last_nxt;
            r_abort_p1 <= w_abort_nxt;
            r_ovf_p1   <= w_ovf_nxt;
        end
    end

    assign M_AXIS_TVALID = r_vld_p1;
    assign M_AXIS_TDATA  = r_data_p1;
    assign M_AXIS_TLAST  = r_last_p1;
    assign M_AXIS_TABORT = r_abort_p1;
    assign o_overflow    = r_ovf_p1;

endmodule

// File: doc/satarx_descrambler.md
# satarx_descrambler

Link-layer receive descrambler for the SATA controller, the receive-side counterpart of the transmit scrambler. Accepts 32-bit frame payload words (SOF/EOF and primitives already stripped, CONT expanded), XORs each with the SATA LFSR sequence restarted at every frame, and forwards the result to the CRC checker. Also enforces a maximum frame length and closes frames cleanly on link-layer abort.

## Interface

- POLYNOMIAL, 16'ha011, Galois LFSR feedback taps (x^16 implicit).
- INITIAL, 16'hffff, LFSR seed at reset and at each frame start; never 0.
- MAX_WORDS, 2049, maximum words per frame (2048 data + CRC); range 2..4095.
- S_AXI_ACLK  in  1  clock; all logic on rising edge.
- S_AXI_ARESET  in  1  reset, synchronous, active-high.
- i_abort  in  1  one-cycle pulse from link FSM: current frame terminated (SYNC/DMAT).
- S_AXIS_TVALID  in  1  scrambled word valid.
- S_AXIS_TREADY  out  1  ready.
- S_AXIS_TDATA  in  32  scrambled word.
- S_AXIS_TLAST  in  1  last word of frame (CRC word).
- M_AXIS_TVALID  out  1  descrambled word valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TDATA  out  32  descrambled word.
- M_AXIS_TLAST  out  1  last word of frame.
- M_AXIS_TABORT  out  1  qualifies TLAST: frame truncated/aborted, discard.
- o_overflow  out  1  one-cycle pulse when a frame exceeds MAX_WORDS.

## Operation

- LFSR per word: 32 steps; step k: prn[k]=fill[15]; fill = {fill[14:0],0} ^ (fill[15] ? POLYNOMIAL : 0). Output TDATA = S_AXIS_TDATA ^ prn; fill advances only on an accepted word.
- Word counter: 12 bits, counts accepted words of current frame; cleared at frame end, abort, reset.
- States:
  - IDLE: fill=INITIAL, count=0. Accepted word -> forward; TLAST ? IDLE : FRAME.
  - FRAME: forward each accepted word. TLAST -> IDLE (fill<=INITIAL). Accepted non-last word number MAX_WORDS -> forwarded with TLAST=1, TABORT=1, o_overflow pulse, -> DROP.
  - DROP: TREADY per handshake rules; accepted words discarded, nothing output; accepted TLAST -> IDLE.
  - ABORT: S_AXIS_TREADY=0; when output slot free, emit TDATA=0, TLAST=1, TABORT=1 -> IDLE.
- i_abort: priority over all input. In FRAME -> ABORT. In DROP -> IDLE. In IDLE -> no effect. Any input word accepted in the abort cycle is discarded and does not advance fill. fill<=INITIAL, count<=0.
- TABORT=0 on all normal words, including normal TLAST.
- Single-word frame (TLAST on first word) legal: IDLE->IDLE, fill reseeded.

## Timing

- Reset values: M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, M_AXIS_TABORT=0, o_overflow=0, state IDLE, fill=INITIAL, count=0. S_AXIS_TREADY=0 during reset.
- Latency: accepted input at edge N appears on M_AXIS at edge N+1 (output register).
- AXI-stream rules: while M_AXIS_TVALID && !M_AXIS_TREADY, TDATA/TLAST/TABORT held stable; TVALID never drops without handshake.
- When output register empty/consumed and no input, TDATA/TLAST/TABORT driven to 0.
- Full throughput: one word per cycle sustained with M_AXIS_TREADY=1.
- Reset mid-frame: output register cleared immediately, no TLAST emitted; next word starts a new frame.
- o_overflow asserted exactly the cycle after the offending word is accepted.

## Configuration

- SATARX_DESCRAMBLER_SKID_EN defined: one-entry skid buffer on input; S_AXIS_TREADY is a register (= skid empty); an input word arriving while output stalled is held in the skid and forwarded next; latency from acceptance still 1 cycle when unstalled.
- Undefined: S_AXIS_TREADY = !M_AXIS_TVALID || M_AXIS_TREADY (combinational, in states other than ABORT/reset); no skid storage.
- Functional output sequence identical in both builds.

## Test plan

- Reset, then frame of 2 words 0x00000000, TLAST on 2nd -> outputs 0xC2D2768D then second PRN word with TLAST=1, TABORT=0; next frame's first zero word again 0xC2D2768D.
- Loop with transmit scrambler, random 1..2049-word frames, random TVALID/TREADY -> byte-exact data and TLAST, no TABORT.
- MAX_WORDS=4, 6-word frame -> 4 words out, 4th TLAST=1 TABORT=1, o_overflow pulse, words 5-6 dropped; following frame starts at 0xC2D2768D.
- i_abort after 3 words of a 10-word frame with M_AXIS_TREADY=0 for 5 cycles -> stalled word stable, then abort word TDATA=0 TLAST=1 TABORT=1; next frame reseeded.
- Reset asserted mid-frame with output stalled -> M_AXIS_TVALID=0 next cycle, all outputs 0.
- Single-word frames back-to-back at full rate -> every output = input ^ 0xC2D2768D, TLAST=1 each, one word/cycle.
